// File: rtl/bfly_tw_pipe.sv
// Radix-2 butterfly with per-lane twiddle on the difference path, NUM_PAIR lanes per beat.
// Four register levels (sum/diff, products, complex combine, round/scale/saturate) give a 3-edge valid-to-output latency.
module bfly_tw_pipe #(
    parameter int WIDTH     = 12,
    parameter int TW_WIDTH  = 16,
    parameter int NUM_PAIR  = 16,
    parameter int BLOCK_LEN = 16
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            bfly_valid,
    input  logic                            scale_en,
    input  logic [WIDTH*NUM_PAIR-1:0]       din_re,
    input  logic [WIDTH*NUM_PAIR-1:0]       din_im,
    input  logic [WIDTH*NUM_PAIR-1:0]       shift_data_re,
    input  logic [WIDTH*NUM_PAIR-1:0]       shift_data_im,
    input  logic [TW_WIDTH*NUM_PAIR-1:0]    tw_re,
    input  logic [TW_WIDTH*NUM_PAIR-1:0]    tw_im,
    output logic [(WIDTH+1)*NUM_PAIR-1:0]   bfly_sum_re,
    output logic [(WIDTH+1)*NUM_PAIR-1:0]   bfly_sum_im,
    output logic [(WIDTH+1)*NUM_PAIR-1:0]   bfly_diff_re,
    output logic [(WIDTH+1)*NUM_PAIR-1:0]   bfly_diff_im,
    output logic                            out_valid,
    output logic                            sat_flag,
    output logic                            block_last
);
    localparam int SW   = WIDTH + 1;
    localparam int PW   = WIDTH + TW_WIDTH + 1;
    localparam int CW   = PW + 1;
    localparam int RW   = CW - (TW_WIDTH - 1);
    localparam int CNTW = $clog2(BLOCK_LEN);

    localparam logic signed [CW-1:0] RND   = CW'(2 ** (TW_WIDTH - 2));
    localparam logic signed [RW-1:0] DMAX  = RW'(2 ** WIDTH - 1);
    localparam logic signed [RW-1:0] DMIN  = RW'(-(2 ** WIDTH));
    localparam logic signed [RW-1:0] R_ONE = RW'(1);
    localparam logic signed [SW:0]   S_ONE = (SW+1)'(1);
    localparam logic [CNTW-1:0]      LAST  = CNTW'(BLOCK_LEN - 1);

    function automatic logic signed [SW-1:0] scale_sum(input logic signed [SW-1:0] s, input logic sc);
        logic signed [SW:0] t;
        t = (SW+1)'(s);
        if (sc) t = (t + S_ONE) >>> 1;
        return SW'(t);
    endfunction

    // Returns {saturated, value}; rounding precedes the optional halving, saturation comes last.
    function automatic logic [SW:0] round_sat(input logic signed [CW-1:0] p, input logic sc);
        logic signed [RW-1:0] r;
        r = RW'((p + RND) >>> (TW_WIDTH - 1));
        if (sc) r = (r + R_ONE) >>> 1;
        if (r > DMAX) return {1'b1, SW'(DMAX)};
        if (r < DMIN) return {1'b1, SW'(DMIN)};
        return {1'b0, SW'(r)};
    endfunction

    logic signed [WIDTH-1:0]    a_re [NUM_PAIR], a_im [NUM_PAIR], b_re [NUM_PAIR], b_im [NUM_PAIR];
    logic signed [TW_WIDTH-1:0] w_re [NUM_PAIR], w_im [NUM_PAIR];

    always_comb begin
        for (int unsigned i = 0; i < NUM_PAIR; i++) begin
            a_re[i] = din_re[i*WIDTH +: WIDTH];
            a_im[i] = din_im[i*WIDTH +: WIDTH];
            b_re[i] = shift_data_re[i*WIDTH +: WIDTH];
            b_im[i] = shift_data_im[i*WIDTH +: WIDTH];
            w_re[i] = tw_re[i*TW_WIDTH +: TW_WIDTH];
            w_im[i] = tw_im[i*TW_WIDTH +: TW_WIDTH];
        end
    end

    logic                       v1, sc1;
    logic signed [SW-1:0]       s1_sum_re [NUM_PAIR], s1_sum_im [NUM_PAIR];
    logic signed [SW-1:0]       s1_dif_re [NUM_PAIR], s1_dif_im [NUM_PAIR];
    logic signed [TW_WIDTH-1:0] tw1_re [NUM_PAIR], tw1_im [NUM_PAIR];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            v1  <= 1'b0;
            sc1 <= 1'b0;
            for (int unsigned i = 0; i < NUM_PAIR; i++) begin
                s1_sum_re[i] <= '0; s1_sum_im[i] <= '0;
                s1_dif_re[i] <= '0; s1_dif_im[i] <= '0;
                tw1_re[i]    <= '0; tw1_im[i]    <= '0;
            end
        end else begin
            v1 <= bfly_valid;
            if (bfly_valid) begin
                sc1 <= scale_en;
                for (int unsigned i = 0; i < NUM_PAIR; i++) begin
                    s1_sum_re[i] <= {a_re[i][WIDTH-1], a_re[i]} + {b_re[i][WIDTH-1], b_re[i]};
                    s1_sum_im[i] <= {a_im[i][WIDTH-1], a_im[i]} + {b_im[i][WIDTH-1], b_im[i]};
                    s1_dif_re[i] <= {a_re[i][WIDTH-1], a_re[i]} - {b_re[i][WIDTH-1], b_re[i]};
                    s1_dif_im[i] <= {a_im[i][WIDTH-1], a_im[i]} - {b_im[i][WIDTH-1], b_im[i]};
                    tw1_re[i]    <= w_re[i];
                    tw1_im[i]    <= w_im[i];
                end
            end
        end
    end

    logic                 v2, sc2;
    logic signed [SW-1:0] s2_sum_re [NUM_PAIR], s2_sum_im [NUM_PAIR];
    logic signed [PW-1:0] rr [NUM_PAIR], ii [NUM_PAIR], ri [NUM_PAIR], ir [NUM_PAIR];

    // Products are widened before multiplying so a -1.0 twiddle times full-scale diff cannot wrap.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            v2  <= 1'b0;
            sc2 <= 1'b0;
            for (int unsigned i = 0; i < NUM_PAIR; i++) begin
                s2_sum_re[i] <= '0; s2_sum_im[i] <= '0;
                rr[i] <= '0; ii[i] <= '0; ri[i] <= '0; ir[i] <= '0;
            end
        end else begin
            v2 <= v1;
            if (v1) begin
                sc2 <= sc1;
                for (int unsigned i = 0; i < NUM_PAIR; i++) begin
                    s2_sum_re[i] <= s1_sum_re[i];
                    s2_sum_im[i] <= s1_sum_im[i];
                    rr[i] <= PW'(s1_dif_re[i]) * PW'(tw1_re[i]);
                    ii[i] <= PW'(s1_dif_im[i]) * PW'(tw1_im[i]);
                    ri[i] <= PW'(s1_dif_re[i]) * PW'(tw1_im[i]);
                    ir[i] <= PW'(s1_dif_im[i]) * PW'(tw1_re[i]);
                end
            end
        end
    end

    logic                 v3, sc3;
    logic signed [SW-1:0] s3_sum_re [NUM_PAIR], s3_sum_im [NUM_PAIR];
    logic signed [CW-1:0] c_re [NUM_PAIR], c_im [NUM_PAIR];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            v3  <= 1'b0;
            sc3 <= 1'b0;
            for (int unsigned i = 0; i < NUM_PAIR; i++) begin
                s3_sum_re[i] <= '0; s3_sum_im[i] <= '0;
                c_re[i] <= '0; c_im[i] <= '0;
            end
        end else begin
            v3 <= v2;
            if (v2) begin
                sc3 <= sc2;
                for (int unsigned i = 0; i < NUM_PAIR; i++) begin
                    s3_sum_re[i] <= s2_sum_re[i];
                    s3_sum_im[i] <= s2_sum_im[i];
                    c_re[i] <= CW'(rr[i]) - CW'(ii[i]);
                    c_im[i] <= CW'(ri[i]) + CW'(ir[i]);
                end
            end
        end
    end

    logic [NUM_PAIR*SW-1:0] n_sum_re, n_sum_im, n_dif_re, n_dif_im;
    logic [NUM_PAIR-1:0]    lane_sat;
    logic [SW:0]            rs_re, rs_im;

    always_comb begin
        n_sum_re = '0; n_sum_im = '0; n_dif_re = '0; n_dif_im = '0;
        lane_sat = '0; rs_re = '0; rs_im = '0;
        for (int unsigned i = 0; i < NUM_PAIR; i++) begin
            rs_re = round_sat(c_re[i], sc3);
            rs_im = round_sat(c_im[i], sc3);
            n_sum_re[i*SW +: SW] = scale_sum(s3_sum_re[i], sc3);
            n_sum_im[i*SW +: SW] = scale_sum(s3_sum_im[i], sc3);
            n_dif_re[i*SW +: SW] = rs_re[SW-1:0];
            n_dif_im[i*SW +: SW] = rs_im[SW-1:0];
            lane_sat[i]          = rs_re[SW] | rs_im[SW];
        end
    end

    logic [CNTW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid    <= 1'b0;
            sat_flag     <= 1'b0;
            block_last   <= 1'b0;
            cnt          <= '0;
            bfly_sum_re  <= '0; bfly_sum_im  <= '0;
            bfly_diff_re <= '0; bfly_diff_im <= '0;
        end else begin
            out_valid <= v3;
            if (v3) begin
                sat_flag     <= |lane_sat;
                block_last   <= (cnt == LAST);
                cnt          <= (cnt == LAST) ? '0 : cnt + CNTW'(1);
                bfly_sum_re  <= n_sum_re; bfly_sum_im  <= n_sum_im;
                bfly_diff_re <= n_dif_re; bfly_diff_im <= n_dif_im;
            end else begin
                sat_flag   <= 1'b0;
                block_last <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bfly_tw_pipe.sv
// Scoreboard bench for bfly_tw_pipe: directed beats push expected results, a negedge monitor pops and compares.
module tb_bfly_tw_pipe;
    localparam int W  = 12;
    localparam int TW = 16;
    localparam int NP = 16;
    localparam int BL = 16;
    localparam int SW = W + 1;

    logic clk = 1'b0;
    logic rstn, bfly_valid, scale_en;
    logic [W*NP-1:0]  din_re, din_im, shift_data_re, shift_data_im;
    logic [TW*NP-1:0] tw_re, tw_im;
    logic [SW*NP-1:0] bfly_sum_re, bfly_sum_im, bfly_diff_re, bfly_diff_im;
    logic out_valid, sat_flag, block_last;

    bfly_tw_pipe #(.WIDTH(W), .TW_WIDTH(TW), .NUM_PAIR(NP), .BLOCK_LEN(BL)) dut (
        .clk(clk), .rstn(rstn), .bfly_valid(bfly_valid), .scale_en(scale_en),
        .din_re(din_re), .din_im(din_im),
        .shift_data_re(shift_data_re), .shift_data_im(shift_data_im),
        .tw_re(tw_re), .tw_im(tw_im),
        .bfly_sum_re(bfly_sum_re), .bfly_sum_im(bfly_sum_im),
        .bfly_diff_re(bfly_diff_re), .bfly_diff_im(bfly_diff_im),
        .out_valid(out_valid), .sat_flag(sat_flag), .block_last(block_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SW*NP-1:0] sr, si, dr, di;
        logic             sat;
        logic             last;
        int unsigned      due;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          nchk = 0;
    int          npass = 0;
    int          exp_cnt = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [W*NP-1:0] rep_w(input int v);
        logic [W*NP-1:0] r;
        for (int i = 0; i < NP; i++) r[i*W +: W] = W'(v);
        return r;
    endfunction

    function automatic logic [TW*NP-1:0] rep_t(input int v);
        logic [TW*NP-1:0] r;
        for (int i = 0; i < NP; i++) r[i*TW +: TW] = TW'(v);
        return r;
    endfunction

    function automatic logic [SW*NP-1:0] rep_s(input int v);
        logic [SW*NP-1:0] r;
        for (int i = 0; i < NP; i++) r[i*SW +: SW] = SW'(v);
        return r;
    endfunction

    function automatic exp_t mk(input int sr, input int si, input int dr, input int di, input logic sat);
        exp_t e;
        e.sr = rep_s(sr); e.si = rep_s(si); e.dr = rep_s(dr); e.di = rep_s(di);
        e.sat = sat; e.last = 1'b0; e.due = 0;
        return e;
    endfunction

    task automatic set_in(input int ar, input int ai, input int br, input int bi,
                          input int wr, input int wi, input logic sc);
        din_re = rep_w(ar); din_im = rep_w(ai);
        shift_data_re = rep_w(br); shift_data_im = rep_w(bi);
        tw_re = rep_t(wr); tw_im = rep_t(wi);
        scale_en = sc;
    endtask

    task automatic beat(input logic track, input exp_t e);
        bfly_valid = 1'b1;
        @(posedge clk); #1;
        bfly_valid = 1'b0;
        if (track) begin
            e.due  = cyc + 3;
            e.last = (exp_cnt == BL - 1);
            exp_cnt = (exp_cnt == BL - 1) ? 0 : exp_cnt + 1;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 20) begin @(posedge clk); n++; end
        @(negedge clk);
        chk("drain_timeout", q.size(), 0);
        #1;
    endtask

    task automatic rst_checks();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sat_flag", sat_flag, 0);
        chk("rst_block_last", block_last, 0);
        chk("rst_sum_re", bfly_sum_re, 0);
        chk("rst_sum_im", bfly_sum_im, 0);
        chk("rst_diff_re", bfly_diff_re, 0);
        chk("rst_diff_im", bfly_diff_im, 0);
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (out_valid) begin
                if (q.size() == 0) chk("unexpected_beat", out_valid, 0);
                else begin
                    mon_e = q.pop_front();
                    chk("sum_re", bfly_sum_re, mon_e.sr);
                    chk("sum_im", bfly_sum_im, mon_e.si);
                    chk("diff_re", bfly_diff_re, mon_e.dr);
                    chk("diff_im", bfly_diff_im, mon_e.di);
                    chk("sat_flag", sat_flag, mon_e.sat);
                    chk("block_last", block_last, mon_e.last);
                    chk("latency", cyc, mon_e.due);
                end
            end else begin
                chk("idle_sat_flag", sat_flag, 0);
                chk("idle_block_last", block_last, 0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rstn = 1'b0; bfly_valid = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 1'b0);
        idle(3);
        rstn = 1'b1;
        rst_checks();

        // identity twiddle
        set_in(30, 130, 40, 230, 32767, 0, 1'b0);
        beat(1'b1, mk(70, 360, -10, -100, 1'b0));
        drain();

        // -j twiddle
        set_in(30, 130, 40, 230, 0, -32768, 1'b0);
        beat(1'b1, mk(70, 360, -100, 10, 1'b0));
        drain();

        // scaling
        set_in(30, 130, 40, 230, 32767, 0, 1'b1);
        beat(1'b1, mk(35, 180, -5, -50, 1'b0));
        drain();

        // saturation on lane 0 only, then identity beat right behind it
        set_in(0, 0, 0, 0, 0, 0, 1'b0);
        din_re[W-1:0] = W'(2047);          din_im[W-1:0] = W'(-2048);
        shift_data_re[W-1:0] = W'(-2048);  shift_data_im[W-1:0] = W'(2047);
        tw_re[TW-1:0] = TW'(-32768);       tw_im[TW-1:0] = TW'(-32768);
        e = mk(0, 0, 0, 0, 1'b1);
        e.sr[SW-1:0] = SW'(-1);
        e.si[SW-1:0] = SW'(-1);
        e.dr[SW-1:0] = SW'(-4096);
        beat(1'b1, e);
        set_in(30, 130, 40, 230, 32767, 0, 1'b0);
        beat(1'b1, mk(70, 360, -10, -100, 1'b0));
        drain();

        // block framing from a fresh counter: 16 beats with 3 bubbles, then 16 back-to-back
        rstn = 1'b0;
        idle(1);
        rstn = 1'b1;
        exp_cnt = 0;
        for (int n = 1; n <= 32; n++) begin
            set_in(n, -n, 0, 0, 32767, 0, 1'b0);
            beat(1'b1, mk(n, -n, n, -n, 1'b0));
            if (n == 4 || n == 9 || n == 12) idle(1);
        end
        drain();

        // reset mid-operation: in-flight beats dropped, counter restarted
        set_in(5, 5, 1, 1, 32767, 0, 1'b0);
        for (int n = 0; n < 3; n++) beat(1'b1, mk(6, 6, 4, 4, 1'b0));
        drain();
        set_in(100, 100, 7, 7, 32767, 0, 1'b1);
        beat(1'b0, mk(0, 0, 0, 0, 1'b0));
        beat(1'b0, mk(0, 0, 0, 0, 1'b0));
        rstn = 1'b0; bfly_valid = 1'b1;
        @(posedge clk); #1;
        rstn = 1'b1; bfly_valid = 1'b0;
        exp_cnt = 0;
        rst_checks();
        idle(6);
        for (int n = 1; n <= 16; n++) begin
            set_in(n, -n, 0, 0, 32767, 0, 1'b0);
            beat(1'b1, mk(n, -n, n, -n, 1'b0));
        end
        drain();

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule

// File: doc/bfly_tw_pipe.md
Name: bfly_tw_pipe

Overview:
Parametrised successor to the radix-2 butterfly. It processes NUM_PAIR complex lanes per beat: sum path a+b, difference path (a-b)*W with a per-lane twiddle. The pipeline has three stages, with optional per-stage scaling, saturation and a saturation flag. A beat counter marks FFT block boundaries. It sits between the stage delay/shift buffer and the next FFT stage, and replaces the separate butterfly plus twiddle hand-off (twiddle_valid).

Parameters:
WIDTH, 12, signed input sample width (re and im).
TW_WIDTH, 16, signed twiddle width, format Q1.(TW_WIDTH-1).
NUM_PAIR, 16, number of parallel butterfly lanes.
BLOCK_LEN, 16, valid output beats per FFT block (>=2).

Ports:
clk  in  1  clock, all logic on rising edge.
rstn  in  1  reset, synchronous, active-low.
bfly_valid  in  1  input beat qualifier.
scale_en  in  1  halve both outputs of this beat; sampled with bfly_valid.
din_re / din_im  in  WIDTH x NUM_PAIR  upper butterfly input a.
shift_data_re / shift_data_im  in  WIDTH x NUM_PAIR  lower butterfly input b.
tw_re / tw_im  in  TW_WIDTH x NUM_PAIR  twiddle W for each lane, sampled with bfly_valid.
bfly_sum_re / bfly_sum_im  out  (WIDTH+1) x NUM_PAIR  a+b, scaled if requested.
bfly_diff_re / bfly_diff_im  out  (WIDTH+1) x NUM_PAIR  (a-b)*W, rounded, saturated, scaled if requested.
out_valid  out  1  output beat qualifier.
sat_flag  out  1  at least one lane saturated on this output beat.
block_last  out  1  high with the BLOCK_LEN-th valid output beat of a block.

Behaviour:
- Reset (rstn=0 at a clk edge):
  - All pipeline valids, out_valid, sat_flag, block_last and the beat counter go to 0.
  - All data registers and outputs go to 0.
  - Beats in flight are discarded and never appear at the output.
- Latency is fixed at 3 cycles: bfly_valid=1 sampled at edge k gives out_valid=1 after edge k+3.
- No backpressure. Back-to-back beats give full throughput. Bubbles propagate as out_valid=0.
- When a stage's valid is 0, its data registers hold their value (no toggling). Outputs hold their last values while out_valid=0. sat_flag and block_last are 0 whenever out_valid=0.
- S1: sum=a+b and diff=a-b, sign-extended to WIDTH+1, no overflow possible. Register scale_en and tw.
- S2: four products diff_re*tw_re, diff_im*tw_im, diff_re*tw_im and diff_im*tw_re, each WIDTH+TW_WIDTH+1 bits signed, registered. Sum is delayed one stage.
- S3 combine:
  - p_re = rr - ii, p_im = ri + ir, with one guard bit.
  - Round half-up: add 2^(TW_WIDTH-2), then arithmetic shift right by TW_WIDTH-1.
- Scaling: if scale_en is set, both sum and the rounded diff are computed as (x+1)>>>1 before saturation.
- Saturate the diff to the WIDTH+1 signed range [-2^WIDTH, 2^WIDTH-1]. The sum never saturates.
- sat_flag = OR over all lanes of the re/im saturation events.
- Twiddle -1.0 (-2^(TW_WIDTH-1)) is legal. Products at full negative scale must not wrap internally.
- Beat counter: 0..BLOCK_LEN-1, increments on each out_valid beat and wraps to 0 after BLOCK_LEN-1. block_last = out_valid && count==BLOCK_LEN-1. Bubbles do not advance the counter.
- Simultaneous reset and bfly_valid: reset wins, and the beat is dropped.

Test Plan:
1. Identity twiddle, with WIDTH=12, TW_WIDTH=16. Drive a=(30,130), b=(40,230), W=(32767,0), scale_en=0, single beat at edge k. Expect out_valid only after edge k+3, sum=(70,360) and diff=(-10,-100) on all lanes, sat_flag=0.
2. -j twiddle. Same a and b, W=(0,-32768). Expect diff=(-100,10) and sum=(70,360).
3. Scaling. Test-1 stimulus with scale_en=1. Expect sum=(35,180) and diff=(-5,-50).
4. Saturation.
   - Drive a=(2047,-2048), b=(-2048,2047), W=(-32768,-32768) on lane 0, zeros on the other lanes.
   - Expect diff lane0=(-4096,0) and sat_flag=1. Other lanes must show 0 with no saturation.
   - Next beat with identity W: sat_flag=0.
5. Block framing, with BLOCK_LEN=16.
   - Drive 16 beats with 3 bubbles inserted.
   - Expect block_last only with the 16th out_valid beat.
   - Drive 16 more beats back-to-back. Expect the second block_last exactly 16 beats later.
6. Reset mid-operation. Drive 2 valid beats, then rstn=0 for 1 cycle on the edge after the second beat. Expect those beats never reach the output, all outputs 0, and the counter restarted (the next block_last after 16 new beats).
